// File: rtl/iob_iob2axi_rd_burst.sv
// AXI4 read master that streams an arbitrary-length word transfer into an IOb
// write-master port, splitting it into INCR bursts bounded by ARLEN and 4 KB pages.
module iob_iob2axi_rd_burst #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int LEN_W      = 16,
    parameter int AXI_LEN_W  = 8,
    parameter int AXI_ID_W   = 1,
    parameter int BOUNDARY_W = 12
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,

    input  logic                  run_i,
    input  logic [ADDR_W-1:0]     addr_i,
    input  logic [LEN_W-1:0]      length_i,
    output logic                  ready_o,
    output logic                  error_o,

    output logic                  m_iob_valid_o,
    output logic [ADDR_W-1:0]     m_iob_addr_o,
    output logic [DATA_W-1:0]     m_iob_wdata_o,
    output logic [DATA_W/8-1:0]   m_iob_wstrb_o,
    input  logic                  m_iob_ready_i,

    output logic [AXI_ID_W-1:0]   m_axi_arid_o,
    output logic [ADDR_W-1:0]     m_axi_araddr_o,
    output logic [AXI_LEN_W-1:0]  m_axi_arlen_o,
    output logic [2:0]            m_axi_arsize_o,
    output logic [1:0]            m_axi_arburst_o,
    output logic                  m_axi_arlock_o,
    output logic [3:0]            m_axi_arcache_o,
    output logic [2:0]            m_axi_arprot_o,
    output logic [3:0]            m_axi_arqos_o,
    output logic                  m_axi_arvalid_o,
    input  logic                  m_axi_arready_i,

    input  logic [DATA_W-1:0]     m_axi_rdata_i,
    input  logic [1:0]            m_axi_rresp_i,
    input  logic                  m_axi_rlast_i,
    input  logic                  m_axi_rvalid_i,
    output logic                  m_axi_rready_o
);

    localparam int SIZE   = $clog2(DATA_W / 8);
    localparam int CW_A   = (LEN_W > BOUNDARY_W) ? LEN_W : BOUNDARY_W;
    localparam int CW     = ((CW_A > AXI_LEN_W) ? CW_A : AXI_LEN_W) + 1;
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'((1 << SIZE) - 1);
    localparam logic [ADDR_W-1:0] WORD_BYTES = ADDR_W'(DATA_W / 8);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] ADDR = 2'd1;
    localparam logic [1:0] DATA = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LEN_W-1:0]  words_left_q, words_left_d;
    logic [ADDR_W-1:0] offset_q, offset_d;
    logic [CW-1:0]     beat_cnt_q, beat_cnt_d;
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic [ADDR_W-1:0] out_addr_q, out_addr_d;
    logic              error_q, error_d;

    logic [CW-1:0]     words_c;
    logic [CW-1:0]     max_c;
    logic [CW-1:0]     bound_c;
    logic [CW-1:0]     beats_c;
    logic              r_hs;
    logic              last_beat;

    // Burst size is the tightest of remaining words, max ARLEN and room left in the page
    always_comb begin
        words_c = CW'(words_left_q);
        max_c   = CW'(1) << AXI_LEN_W;
        bound_c = ((CW'(1) << BOUNDARY_W) - CW'(addr_q[BOUNDARY_W-1:0])) >> SIZE;
        beats_c = words_c;
        if (max_c < beats_c) begin
            beats_c = max_c;
        end
        if (bound_c < beats_c) begin
            beats_c = bound_c;
        end
    end

    assign m_axi_arid_o    = '0;
    assign m_axi_araddr_o  = addr_q;
    assign m_axi_arlen_o   = AXI_LEN_W'(beats_c - CW'(1));
    assign m_axi_arsize_o  = 3'(SIZE);
    assign m_axi_arburst_o = 2'b01;
    assign m_axi_arlock_o  = 1'b0;
    assign m_axi_arcache_o = 4'b0010;
    assign m_axi_arprot_o  = 3'b010;
    assign m_axi_arqos_o   = 4'b0000;
    assign m_axi_arvalid_o = (state_q == ADDR);

    assign m_axi_rready_o  = (state_q == DATA) & (~out_valid_q | m_iob_ready_i);
    assign r_hs            = m_axi_rvalid_i & m_axi_rready_o;
    assign last_beat       = (beat_cnt_q == CW'(1));

    assign ready_o         = (state_q == IDLE) & ~out_valid_q;
    assign error_o         = error_q;
    assign m_iob_valid_o   = out_valid_q;
    assign m_iob_addr_o    = out_addr_q;
    assign m_iob_wdata_o   = out_data_q;
    assign m_iob_wstrb_o   = '1;

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        words_left_d = words_left_q;
        offset_d     = offset_q;
        beat_cnt_d   = beat_cnt_q;
        error_d      = error_q;

        case (state_q)
            IDLE: begin
                if (run_i && ready_o) begin
                    addr_d       = addr_i & ALIGN_MASK;
                    words_left_d = length_i;
                    offset_d     = '0;
                    error_d      = 1'b0;
                    if (length_i != '0) begin
                        state_d = ADDR;
                    end
                end
            end
            ADDR: begin
                if (m_axi_arready_i) begin
                    beat_cnt_d   = beats_c;
                    addr_d       = addr_q + (ADDR_W'(beats_c) << SIZE);
                    words_left_d = words_left_q - LEN_W'(beats_c);
                    state_d      = DATA;
                end
            end
            DATA: begin
                if (r_hs) begin
                    beat_cnt_d = beat_cnt_q - CW'(1);
                    offset_d   = offset_q + WORD_BYTES;
                    // Errors are recorded but never stop delivery of the remaining beats
                    error_d    = error_q | (m_axi_rresp_i != 2'b00) | (m_axi_rlast_i != last_beat);
                    if (last_beat) begin
                        state_d = (words_left_q != '0) ? ADDR : IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // One-entry output register; a new beat can replace the old one in the same cycle it is accepted
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_addr_d  = out_addr_q;
        if (r_hs) begin
            out_valid_d = 1'b1;
            out_data_d  = m_axi_rdata_i;
            out_addr_d  = offset_q;
        end else if (m_iob_ready_i) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            words_left_q <= '0;
            offset_q     <= '0;
            beat_cnt_q   <= '0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_addr_q   <= '0;
            error_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            words_left_q <= words_left_d;
            offset_q     <= offset_d;
            beat_cnt_q   <= beat_cnt_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_addr_q   <= out_addr_d;
            error_q      <= error_d;
        end
    end

endmodule

// File: tb/tb_iob_iob2axi_rd_burst.sv
// Scoreboard bench: a reference model splits each transfer into bursts and words,
// a random AXI slave/IOb sink drives the DUT, and a monitor pops and compares.
module tb_iob_iob2axi_rd_burst;

    localparam int ADDR_W     = 32;
    localparam int DATA_W     = 32;
    localparam int LEN_W      = 16;
    localparam int AXI_LEN_W  = 8;
    localparam int AXI_ID_W   = 1;
    localparam int BOUNDARY_W = 12;
    localparam int NB         = DATA_W / 8;
    localparam int BUDGET     = 20000;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 run = 1'b0;
    logic [ADDR_W-1:0]    addr_in = '0;
    logic [LEN_W-1:0]     length_in = '0;
    logic                 ready_o, error_o;
    logic                 m_iob_valid;
    logic [ADDR_W-1:0]    m_iob_addr;
    logic [DATA_W-1:0]    m_iob_wdata;
    logic [NB-1:0]        m_iob_wstrb;
    logic                 m_iob_ready = 1'b0;
    logic [AXI_ID_W-1:0]  arid;
    logic [ADDR_W-1:0]    araddr;
    logic [AXI_LEN_W-1:0] arlen;
    logic [2:0]           arsize;
    logic [1:0]           arburst;
    logic                 arlock;
    logic [3:0]           arcache;
    logic [2:0]           arprot;
    logic [3:0]           arqos;
    logic                 arvalid;
    logic                 arready = 1'b0;
    logic [DATA_W-1:0]    rdata = '0;
    logic [1:0]           rresp = '0;
    logic                 rlast = 1'b0;
    logic                 rvalid = 1'b0;
    logic                 rready;

    iob_iob2axi_rd_burst #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W),
        .AXI_LEN_W(AXI_LEN_W), .AXI_ID_W(AXI_ID_W), .BOUNDARY_W(BOUNDARY_W)
    ) dut (
        .clk_i(clk), .rst_n_i(rst_n),
        .run_i(run), .addr_i(addr_in), .length_i(length_in),
        .ready_o(ready_o), .error_o(error_o),
        .m_iob_valid_o(m_iob_valid), .m_iob_addr_o(m_iob_addr),
        .m_iob_wdata_o(m_iob_wdata), .m_iob_wstrb_o(m_iob_wstrb),
        .m_iob_ready_i(m_iob_ready),
        .m_axi_arid_o(arid), .m_axi_araddr_o(araddr), .m_axi_arlen_o(arlen),
        .m_axi_arsize_o(arsize), .m_axi_arburst_o(arburst), .m_axi_arlock_o(arlock),
        .m_axi_arcache_o(arcache), .m_axi_arprot_o(arprot), .m_axi_arqos_o(arqos),
        .m_axi_arvalid_o(arvalid), .m_axi_arready_i(arready),
        .m_axi_rdata_i(rdata), .m_axi_rresp_i(rresp), .m_axi_rlast_i(rlast),
        .m_axi_rvalid_i(rvalid), .m_axi_rready_o(rready)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] addr; int len; } ar_t;
    typedef struct { logic [31:0] off; logic [31:0] data; } iob_t;

    ar_t  exp_ar[$];
    iob_t exp_iob[$];
    ar_t  burst_q[$];

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int iob_seen = 0;
    int last_hs_cyc = 0;
    int beat_in_burst = 0;
    int xfer_beat = 0;
    int inj_resp_beat = -1;
    int inj_rlast_beat = -1;
    int ar_rate = 100;
    int r_rate = 100;
    int iob_rate = 100;
    bit force_low = 1'b0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // AXI slave and IOb sink: drive on the falling edge, record handshakes before the rising edge
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            arready     = ($urandom_range(99) < ar_rate);
            m_iob_ready = force_low ? 1'b0 : ($urandom_range(99) < iob_rate);
            if (burst_q.size() > 0 && $urandom_range(99) < r_rate) begin
                rvalid = 1'b1;
                rdata  = mem_word(burst_q[0].addr + 32'(beat_in_burst * NB));
                rresp  = (xfer_beat == inj_resp_beat) ? 2'b10 : 2'b00;
                rlast  = (beat_in_burst == burst_q[0].len) || (xfer_beat == inj_rlast_beat);
            end else begin
                rvalid = 1'b0;
                rdata  = '0;
                rresp  = 2'b00;
                rlast  = 1'b0;
            end
            #1;
            if (rst_n) begin
                if (arvalid && arready) begin
                    burst_q.push_back('{araddr, int'(arlen)});
                end
                if (rvalid && rready && burst_q.size() > 0) begin
                    xfer_beat++;
                    if (beat_in_burst == burst_q[0].len) begin
                        void'(burst_q.pop_front());
                        beat_in_burst = 0;
                    end else begin
                        beat_in_burst++;
                    end
                end
            end
        end
    end

    // Monitor: pops the scoreboard on every AR and IOb handshake
    initial begin
        ar_t  ea;
        iob_t ei;
        forever begin
            @(negedge clk);
            #2;
            if (rst_n) begin
                if (arvalid && arready) begin
                    if (exp_ar.size() == 0) begin
                        checkOutput("ar_extra", 64'(araddr), 64'hFFFF_FFFF_FFFF_FFFF);
                    end else begin
                        ea = exp_ar.pop_front();
                        checkOutput("araddr", 64'(araddr), 64'(ea.addr));
                        checkOutput("arlen", 64'(arlen), 64'(ea.len));
                        checkOutput("ar_const",
                            64'({arid, arsize, arburst, arlock, arcache, arprot, arqos}),
                            64'({1'b0, 3'd2, 2'b01, 1'b0, 4'b0010, 3'b010, 4'b0000}));
                    end
                end
                if (m_iob_valid && m_iob_ready) begin
                    iob_seen++;
                    last_hs_cyc = cyc;
                    if (exp_iob.size() == 0) begin
                        checkOutput("iob_extra", 64'(m_iob_addr), 64'hFFFF_FFFF_FFFF_FFFF);
                    end else begin
                        ei = exp_iob.pop_front();
                        checkOutput("iob_offset", 64'(m_iob_addr), 64'(ei.off));
                        checkOutput("iob_data", 64'(m_iob_wdata), 64'(ei.data));
                        checkOutput("iob_wstrb", 64'(m_iob_wstrb), 64'hF);
                    end
                end
            end
        end
    end

    // Reference model: split into bursts by remaining words, 256 beats and 4 KB pages
    task automatic applyStimulus(input logic [31:0] addr, input int len);
        logic [31:0] a;
        int left, b, room, off;
        a    = addr & 32'hFFFF_FFFC;
        left = len;
        off  = 0;
        while (left > 0) begin
            b    = (left > 256) ? 256 : left;
            room = (4096 - int'(a % 4096)) / NB;
            if (b > room) b = room;
            exp_ar.push_back('{a, b - 1});
            for (int i = 0; i < b; i++) begin
                exp_iob.push_back('{32'(off), mem_word(a + 32'(i * NB))});
                off += NB;
            end
            a    += 32'(b * NB);
            left -= b;
        end
        xfer_beat = 0;
        @(negedge clk);
        run       = 1'b1;
        addr_in   = addr;
        length_in = LEN_W'(len);
        @(negedge clk);
        run = 1'b0;
        #3;
        checkOutput("err_clear", 64'(error_o), 64'd0);
        checkOutput("ready_after_run", 64'(ready_o), 64'(len == 0));
    endtask

    task automatic finishXfer(input int len, input bit exp_err);
        int n;
        n = 0;
        while (n < BUDGET) begin
            @(negedge clk);
            #3;
            if (ready_o) break;
            n++;
        end
        if (n >= BUDGET) begin
            checkOutput("timeout_ready", 64'd0, 64'd1);
            exp_ar.delete();
            exp_iob.delete();
        end
        checkOutput("ar_pending", 64'(exp_ar.size()), 64'd0);
        checkOutput("iob_pending", 64'(exp_iob.size()), 64'd0);
        checkOutput("error_final", 64'(error_o), 64'(exp_err));
        if (len > 0) begin
            checkOutput("ready_latency", 64'(cyc - last_hs_cyc), 64'd1);
        end
    endtask

    task automatic waitIobCount(input int target);
        int n;
        n = 0;
        while (iob_seen < target && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (iob_seen < target) checkOutput("wait_iob", 64'd0, 64'd1);
    endtask

    initial begin
        #(10 * 90000);
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int base, len;
        logic [31:0] addr;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #3;
        checkOutput("rst_ready", 64'(ready_o), 64'd1);
        checkOutput("rst_outputs", 64'({error_o, m_iob_valid, arvalid, rready}), 64'd0);

        $display("[TB] basic 4-word transfer");
        applyStimulus(32'h0, 4);
        finishXfer(4, 1'b0);

        $display("[TB] 600-word transfer, three bursts");
        applyStimulus(32'h0, 600);
        finishXfer(600, 1'b0);

        $display("[TB] 4 KB boundary split");
        applyStimulus(32'hFF0, 8);
        finishXfer(8, 1'b0);

        $display("[TB] IOb backpressure mid-burst");
        ar_rate = 100; r_rate = 100; iob_rate = 100;
        base = iob_seen;
        applyStimulus(32'h200, 16);
        waitIobCount(base + 4);
        force_low = 1'b1;
        repeat (5) begin
            @(negedge clk);
            #3;
            if (m_iob_valid) checkOutput("rready_hold", 64'(rready), 64'd0);
            else checkOutput("valid_hold", 64'(m_iob_valid), 64'd1);
        end
        force_low = 1'b0;
        finishXfer(16, 1'b0);

        $display("[TB] RRESP error on beat 2");
        inj_resp_beat = 2;
        applyStimulus(32'h100, 4);
        finishXfer(4, 1'b1);
        inj_resp_beat = -1;
        applyStimulus(32'h100, 4);
        finishXfer(4, 1'b0);

        $display("[TB] early RLAST on beat 1");
        inj_rlast_beat = 1;
        applyStimulus(32'h300, 4);
        finishXfer(4, 1'b1);
        inj_rlast_beat = -1;

        $display("[TB] zero-length run");
        applyStimulus(32'h400, 0);
        finishXfer(0, 1'b0);
        repeat (3) begin
            @(negedge clk);
            #3;
            checkOutput("zero_len_ready", 64'(ready_o), 64'd1);
        end

        $display("[TB] reset mid-burst");
        ar_rate = 70; r_rate = 70; iob_rate = 70;
        base = iob_seen;
        applyStimulus(32'h800, 64);
        waitIobCount(base + 10);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        exp_ar.delete();
        exp_iob.delete();
        burst_q.delete();
        beat_in_burst = 0;
        #3;
        checkOutput("midrst_ready", 64'(ready_o), 64'd1);
        checkOutput("midrst_outputs", 64'({error_o, m_iob_valid, arvalid, rready}), 64'd0);
        applyStimulus(32'h40, 2);
        finishXfer(2, 1'b0);

        $display("[TB] randomized transfers");
        for (int k = 0; k < 6; k++) begin
            ar_rate  = int'($urandom_range(30, 100));
            r_rate   = int'($urandom_range(30, 100));
            iob_rate = int'($urandom_range(30, 100));
            addr     = 32'($urandom_range(0, 32'h3FFF));
            len      = int'($urandom_range(1, 300));
            applyStimulus(addr, len);
            finishXfer(len, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
